// File: rtl/ingress_shaper.sv
// ingress_shaper: per-port ingress queue, route filter and token-bucket shaper
// sitting directly in front of one switch_4port input port.
// Optional build macro: SHAPER_STATS_EN builds the sent/drop statistics
// counters; without it sent_cnt and drop_cnt read as zero.
module ingress_shaper #(
  parameter int PORT_ID       = 0,
  parameter int PACKET_WIDTH  = 16,
  parameter int QDEPTH        = 4,
  parameter int BUCKET_MAX    = 8,
  parameter int REFILL_PERIOD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACKET_WIDTH-1:0] in_pkt,
  input  logic                    port_full,
  output logic                    valid_in,
  output logic [PACKET_WIDTH-1:0] pkt_out,
  output logic [3:0]              target_in,
  output logic [3:0]              source_in,
  output logic                    idle,
  output logic [15:0]             sent_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUCKET_MAX + 1);
  localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  // Source field is rewritten on the way out, so only [W-1:4] is stored.
  localparam int DW = PACKET_WIDTH - 4;

  localparam logic [3:0]    SRC_ID   = 4'(1 << PORT_ID);
  localparam logic [TW-1:0] TOK_MAX  = TW'(BUCKET_MAX);
  localparam logic [AW-1:0] PTR_LAST = AW'(QDEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
  localparam logic [RW-1:0] RF_LAST  = RW'(REFILL_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, EVAL, WAIT, SEND, DROP} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [TW-1:0] tokens_q, tokens_d;
  logic [RW-1:0] refill_q, refill_d;
  logic [TW:0]   tok_sum;

  logic          full, empty, push, pop, spend, refill, is_drop;
  logic          illegal, can_send, more_left;
  logic [DW-1:0] head;
  logic [3:0]    head_tgt;
  logic [2:0]    cost;
  logic          unused_src;

  assign unused_src = ^in_pkt[3:0];

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  assign head     = mem_q[rd_ptr_q];
  assign head_tgt = head[3:0];
  assign cost     = 3'($countones(head_tgt));

  assign illegal  = (head_tgt == 4'b0000) || head_tgt[PORT_ID];
  assign can_send = (tokens_q >= TW'(cost)) && !port_full;

  assign spend    = (state_q == SEND) && !port_full;
  assign is_drop  = (state_q == DROP);
  assign pop      = spend | is_drop;
  // A push landing on the retire cycle keeps the queue non-empty.
  assign more_left = (count_q > CW'(1)) || push;

  assign refill   = (refill_q == RF_LAST);

  assign pkt_out   = empty ? '0 : {head, SRC_ID};
  assign target_in = pkt_out[7:4];
  assign source_in = pkt_out[3:0];
  assign idle      = empty && (state_q == IDLE);

  // Queue storage: written on accept only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_pkt[PACKET_WIDTH-1:4];
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Queue pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Token bucket: spend and refill may coincide; result clamps at capacity.
  always_comb begin
    refill_d = refill ? '0 : refill_q + RW'(1);
    tok_sum  = {1'b0, tokens_q};
    if (spend)  tok_sum = tok_sum - (TW+1)'(cost);
    if (refill) tok_sum = tok_sum + (TW+1)'(1);
    tokens_d = (tok_sum > {1'b0, TOK_MAX}) ? TOK_MAX : tok_sum[TW-1:0];
  end

  // Token bucket and refill timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tokens_q <= TOK_MAX;
      refill_q <= '0;
    end else begin
      tokens_q <= tokens_d;
      refill_q <= refill_d;
    end
  end

  // FSM next-state and issue strobe.
  always_comb begin
    state_d  = state_q;
    valid_in = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) state_d = EVAL;
      EVAL: begin
        if (illegal)       state_d = DROP;
        else if (can_send) state_d = SEND;
        else               state_d = WAIT;
      end
      WAIT: if (can_send) state_d = SEND;
      SEND: begin
        if (!port_full) begin
          valid_in = 1'b1;
          state_d  = more_left ? EVAL : IDLE;
        end
      end
      DROP: state_d = more_left ? EVAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef SHAPER_STATS_EN
  logic [15:0] sent_q, sent_d;
  logic [15:0] drop_q, drop_d;

  // Saturating statistics counters next-state.
  always_comb begin
    sent_d = sent_q;
    drop_d = drop_q;
    if (spend && (sent_q != '1))   sent_d = sent_q + 16'd1;
    if (is_drop && (drop_q != '1)) drop_d = drop_q + 16'd1;
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q <= '0;
      drop_q <= '0;
    end else begin
      sent_q <= sent_d;
      drop_q <= drop_d;
    end
  end

  assign sent_cnt = sent_q;
  assign drop_cnt = drop_q;
`else
  assign sent_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ingress_shaper.sv
// Directed testbench for ingress_shaper: two instances (PORT_ID 0 and 1),
// hand-computed expected values, edge-counted timeline after each reset.
module tb_ingress_shaper;

`ifdef SHAPER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid0, in_ready0, port_full0, valid_in0, idle0;
  logic [15:0] in_pkt0, pkt_out0, sent0, drop0;
  logic [3:0]  tgt0, src0;

  logic        in_valid1, in_ready1, port_full1, valid_in1, idle1;
  logic [15:0] in_pkt1, pkt_out1, sent1, drop1;
  logic [3:0]  tgt1, src1;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int idx;
  int n_iss;
  int iss_cyc [8];
  logic [7:0] iss_pay [8];
  logic acc;

  ingress_shaper #(.PORT_ID(0), .PACKET_WIDTH(16), .QDEPTH(4),
                   .BUCKET_MAX(8), .REFILL_PERIOD(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_pkt(in_pkt0), .port_full(port_full0), .valid_in(valid_in0),
    .pkt_out(pkt_out0), .target_in(tgt0), .source_in(src0), .idle(idle0),
    .sent_cnt(sent0), .drop_cnt(drop0));

  ingress_shaper #(.PORT_ID(1), .PACKET_WIDTH(16), .QDEPTH(4),
                   .BUCKET_MAX(8), .REFILL_PERIOD(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_pkt(in_pkt1), .port_full(port_full1), .valid_in(valid_in1),
    .pkt_out(pkt_out1), .target_in(tgt1), .source_in(src1), .idle(idle1),
    .sent_cnt(sent1), .drop_cnt(drop1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid0  = 1'b0; in_pkt0 = '0; port_full0 = 1'b0;
    in_valid1  = 1'b0; in_pkt1 = '0; port_full1 = 1'b0;
    n_iss      = 0;
    idx        = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic record_issue();
    if (valid_in0 && n_iss < 8) begin
      iss_cyc[n_iss] = cyc;
      iss_pay[n_iss] = pkt_out0[15:8];
      n_iss++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- reset state + single packet, PORT_ID 0 ----
    do_reset();
    check("rst_idle",   idle0, 1);
    check("rst_ready",  in_ready0, 1);
    check("rst_valid",  valid_in0, 0);
    check("rst_pkt",    pkt_out0, 16'h0000);
    check("rst_tokens", dut0.tokens_q, 8);
    check("rst_sent",   sent0, 0);
    check("rst_drop",   drop0, 0);
    step();                                   // E1
    in_valid0 = 1'b1; in_pkt0 = 16'hAB6F;
    step();                                   // E2: accepted
    in_valid0 = 1'b0;
    check("t1_valid_e2", valid_in0, 0);
    step();                                   // E3: EVAL
    check("t1_valid_e3", valid_in0, 0);
    step();                                   // E4: SEND
    check("t1_valid_e4", valid_in0, 1);
    check("t1_pkt",      pkt_out0, 16'hAB61);
    check("t1_src",      src0, 4'b0001);
    check("t1_tgt",      tgt0, 4'b0110);
    step();                                   // E5: retired
    check("t1_valid_e5", valid_in0, 0);
    check("t1_tokens",   dut0.tokens_q, 6);
    check("t1_sent",     sent0, STATS);
    check("t1_idle",     idle0, 1);

    // ---- illegal routes, PORT_ID 1 ----
    do_reset();
    in_valid1 = 1'b1; in_pkt1 = 16'h1203;     // target 0000
    step();                                   // E1
    in_pkt1 = 16'h3425;                       // target 0010 (own port)
    step();                                   // E2
    in_valid1 = 1'b0;
    check("t2_valid_e2", valid_in1, 0);
    step();                                   // E3: DROP
    check("t2_valid_e3", valid_in1, 0);
    check("t2_idle_e3",  idle1, 0);
    step();                                   // E4: first popped
    check("t2_valid_e4", valid_in1, 0);
    check("t2_drop_e4",  drop1, STATS);
    check("t2_idle_e4",  idle1, 0);
    step();                                   // E5: DROP
    check("t2_valid_e5", valid_in1, 0);
    check("t2_idle_e5",  idle1, 0);
    step();                                   // E6: second popped
    check("t2_idle_e6",  idle1, 1);
    check("t2_drop_e6",  drop1, 2 * STATS);
    check("t2_tokens",   dut1.tokens_q, 8);
    check("t2_ready",    in_ready1, 1);
    check("t2_sent",     sent1, 0);

    // ---- backpressure held in SEND ----
    do_reset();
    in_valid0 = 1'b1; in_pkt0 = 16'h5543;
    step();                                   // E1
    in_valid0 = 1'b0;
    step();                                   // E2: EVAL
    step();                                   // E3: SEND
    check("t3_valid_send", valid_in0, 1);
    port_full0 = 1'b1;
    #1;
    check("t3_valid_full", valid_in0, 0);
    for (int i = 0; i < 21; i++) begin        // E4..E24
      step();
      check("t3_hold_valid",  valid_in0, 0);
      check("t3_hold_pkt",    pkt_out0, 16'h5541);
      check("t3_hold_tokens", dut0.tokens_q, 8);
    end
    port_full0 = 1'b0;
    #1;
    check("t3_release_valid", valid_in0, 1);
    step();                                   // E25: retired
    check("t3_after_valid",  valid_in0, 0);
    check("t3_after_tokens", dut0.tokens_q, 7);
    check("t3_after_idle",   idle0, 1);
    step();
    check("t3_once", valid_in0, 0);

    // ---- rate limit: four cost-3 packets ----
    do_reset();
    step();                                   // E1
    in_valid0 = 1'b1; in_pkt0 = {8'hC0, 4'b1110, 4'h0};
    for (int i = 0; i < 27; i++) begin        // E2..E28
      acc = in_valid0 && in_ready0;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) in_pkt0 = {8'hC0 + 8'(idx), 4'b1110, 4'h0};
        else         in_valid0 = 1'b0;
      end
      record_issue();
      if (cyc == 7)  check("t4_tokens_e7",  dut0.tokens_q, 2);
      if (cyc == 22) check("t4_tokens_e22", dut0.tokens_q, 0);
    end
    check("t4_n_issued", n_iss, 4);
    check("t4_iss0_cyc", iss_cyc[0], 4);
    check("t4_iss1_cyc", iss_cyc[1], 6);
    check("t4_iss2_cyc", iss_cyc[2], 9);
    check("t4_iss3_cyc", iss_cyc[3], 21);
    for (int i = 0; i < 4; i++) check("t4_order", iss_pay[i], 8'hC0 + 8'(i));
    check("t4_idle", idle0, 1);

    // ---- queue full under backpressure ----
    do_reset();
    port_full0 = 1'b1;
    in_valid0  = 1'b1; in_pkt0 = {8'hD0, 4'b0010, 4'h0};
    for (int i = 0; i < 8; i++) begin         // E1..E8
      acc = in_valid0 && in_ready0;
      step();
      if (acc) begin
        idx++;
        if (idx < 5) in_pkt0 = {8'hD0 + 8'(idx), 4'b0010, 4'h0};
        else         in_valid0 = 1'b0;
      end
      check("t5_hold_valid", valid_in0, 0);
      if (cyc == 3) check("t5_ready_e3", in_ready0, 1);
      if (cyc == 4) check("t5_ready_e4", in_ready0, 0);
    end
    check("t5_accepts", idx, 4);
    check("t5_ready_held", in_ready0, 0);
    port_full0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      acc = in_valid0 && in_ready0;
      step();
      if (acc) begin
        idx++;
        if (idx < 5) in_pkt0 = {8'hD0 + 8'(idx), 4'b0010, 4'h0};
        else         in_valid0 = 1'b0;
      end
      record_issue();
    end
    check("t5_n_issued", n_iss, 5);
    for (int i = 0; i < 5; i++) check("t5_order", iss_pay[i], 8'hD0 + 8'(i));
    check("t5_idle", idle0, 1);

    // ---- reset while in SEND with three queued ----
    do_reset();
    in_valid0 = 1'b1; in_pkt0 = {8'hE0, 4'b0100, 4'h0};
    for (int i = 0; i < 3; i++) begin         // E1..E3
      acc = in_valid0 && in_ready0;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) in_pkt0 = {8'hE0 + 8'(idx), 4'b0100, 4'h0};
        else         in_valid0 = 1'b0;
      end
    end
    check("t6_valid_pre", valid_in0, 1);
    check("t6_pkt_pre",   pkt_out0, 16'hE041);
    check("t6_idle_pre",  idle0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_valid_async", valid_in0, 0);
    check("t6_idle_async",  idle0, 1);
    check("t6_pkt_async",   pkt_out0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_idle",   idle0, 1);
    check("t6_ready",  in_ready0, 1);
    check("t6_tokens", dut0.tokens_q, 8);
    check("t6_sent",   sent0, 0);
    check("t6_drop",   drop0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_flushed_valid", valid_in0, 0);
      check("t6_flushed_idle",  idle0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ingress_shaper.md
Name: ingress_shaper

Overview:
- Sits directly upstream of one switch_4port input port; one instance per port.
- Buffers packets from the traffic source and filters illegal routes.
- Rate-limits with a token bucket, charging one token per destination.
- Never presents a packet while the port FIFO reports full, so accepted traffic is never rejected at switch ingress.

Parameters:
- PORT_ID, 0, switch port index this instance feeds (0..3).
- PACKET_WIDTH, 16, packet width; [3:0] source, [7:4] target (one bit per destination port), [PACKET_WIDTH-1:8] payload.
- QDEPTH, 4, internal queue entries (power of two, >=2).
- BUCKET_MAX, 8, token bucket capacity (>=4).
- REFILL_PERIOD, 4, cycles per added token (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  source offers in_pkt.
- in_ready  out  1  queue not full; transfer on in_valid&&in_ready.
- in_pkt  in  PACKET_WIDTH  offered packet.
- port_full  in  1  switch port FIFO full.
- valid_in  out  1  packet presented to the switch port this cycle.
- pkt_out  out  PACKET_WIDTH  packet to the switch; source field rewritten.
- target_in  out  4  pkt_out[7:4].
- source_in  out  4  pkt_out[3:0].
- idle  out  1  queue empty and FSM in IDLE.
- sent_cnt  out  16  packets issued (stats).
- drop_cnt  out  16  packets filtered (stats).

Behaviour:
- Reset values:
  - valid_in=0, pkt_out=0, queue empty, in_ready=1, idle=1.
  - FSM=IDLE, tokens=BUCKET_MAX, refill counter=0, both counters=0.
- Queue:
  - FIFO of QDEPTH entries; in_ready=!full.
  - Push on accept; pop only when the head retires (SEND with valid_in=1, or DROP).
  - Simultaneous push and pop when full is not possible, because in_ready=0 when full.
  - Pointers wrap modulo QDEPTH.
- Cost: cost = $countones(head target), range 0..4.
- FSM states: IDLE, EVAL, WAIT, SEND, DROP.
  - IDLE: queue non-empty -> EVAL.
  - EVAL: if target==0 or target[PORT_ID]==1 -> DROP. Else if tokens>=cost and !port_full -> SEND. Else -> WAIT.
  - WAIT: re-checks the same conditions every cycle -> SEND when both hold.
  - SEND: valid_in = !port_full (combinational).
    - port_full=1: hold SEND, no token spent, no pop.
    - valid_in=1: retire head, tokens-=cost, sent_cnt++. Next state is EVAL if more entries remain, else IDLE.
  - DROP: one cycle; pop head, drop_cnt++. Next state is EVAL or IDLE.
- Latency: a packet accepted at edge N into an empty queue, with tokens available and port not full, gives valid_in=1 in the cycle after edge N+2.
- Issue rate: at most one packet per 2 cycles (SEND->EVAL).
- Output fields:
  - pkt_out holds the head entry with [3:0] replaced by 4'b1<<PORT_ID.
  - pkt_out is stable whenever the FSM is in SEND.
- Tokens:
  - The refill counter runs 0..REFILL_PERIOD-1 and wraps.
  - On wrap, +1 token, saturating at BUCKET_MAX.
  - Same-cycle spend and refill: tokens_next = min(tokens-cost+1, BUCKET_MAX).
  - Tokens never go below 0; a spend requires tokens>=cost.
- Counters: 16-bit, saturate at 0xFFFF.
- Asserting rst mid-operation: queue flushed, in-flight packet lost, valid_in drops immediately (asynchronous), all state returns to reset values.

Optional Feature:
- SHAPER_STATS_EN defined: sent_cnt and drop_cnt are live as specified.
- Undefined: no counter registers are built; sent_cnt and drop_cnt are tied to 0. All other behaviour is identical.

Test Plan:
- Single packet, PORT_ID=0, target=4'b0110, tokens=8, port_full=0 -> valid_in high 2 cycles after accept, source_in=4'b0001, tokens=6, sent_cnt=1.
- Illegal routes, PORT_ID=1, targets 4'b0000 then 4'b0010 -> no valid_in, drop_cnt=2, both consumed in 2 cycles each, queue empty.
- Backpressure: port_full=1 held 20 cycles while a packet sits in SEND -> valid_in=0 throughout, pkt_out stable, tokens unchanged. Release port_full -> valid_in pulses once.
- Rate limit, BUCKET_MAX=8, REFILL_PERIOD=4: 4 back-to-back packets with target=4'b1110 (cost 3) -> first two issue at 2-cycle spacing. The third waits in WAIT until tokens>=3; fourth follows per refill. No port ever overdrawn.
- Queue full: 5 packets offered while port_full=1 -> in_ready=0 after 4 accepts; 5th held at source. Nothing lost after release; order preserved.
- Reset asserted while in SEND with 3 queued -> valid_in=0 same cycle; after release idle=1, tokens=8, counters=0.
